// File: rtl/streaming_convolution.sv
// Streaming KERNEL_SIZE x KERNEL_SIZE 2-D convolution over a raster pixel stream, 3-stage pipeline.
// Optional macro CONV_SATURATE_EN: clip results to the WORD_SIZE range instead of wrapping.
module streaming_convolution #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned SHIFT       = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [WORD_SIZE-1:0] pixel_in,
  input  logic                        pixel_valid,
  input  logic                        sof,
  input  logic signed [WORD_SIZE-1:0] kernel_in [KERNEL_SIZE][KERNEL_SIZE],
  input  logic                        kernel_load,
  output logic signed [WORD_SIZE-1:0] ans,
  output logic                        ans_valid
);

  localparam int unsigned K  = KERNEL_SIZE;
  localparam int unsigned PW = 2 * WORD_SIZE;
  localparam int unsigned AW = PW + $clog2(K * K);
  localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW = $clog2(K);

  typedef logic signed [WORD_SIZE-1:0] word_t;
  typedef logic signed [PW-1:0]        prod_t;
  typedef logic signed [AW-1:0]        acc_t;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          win_done;

  word_t lb_q   [K-1][IMG_WIDTH];
  word_t win_q  [K][K];
  word_t win_d  [K][K];
  word_t tap    [K];
  word_t coef_q [K][K];
  prod_t prod_q [K][K];
  acc_t  rsum_q [K];
  acc_t  rsum_d [K];
  acc_t  total;
  word_t ans_d, ans_q;
  logic  v1_q, v2_q, ans_valid_q;

  // sof overrides the counters for the pixel it qualifies, even mid-row.
  always_comb begin
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    win_done = pixel_valid && (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (pixel_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(K - 1)) ? cur_row : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // Column taps: tap[K-1] is the current row, tap[0] the oldest buffered row.
  always_comb begin
    for (int i = 0; i < K - 1; i++) begin
      tap[i] = lb_q[K-2-i][cur_col];
    end
    tap[K-1] = pixel_in;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
      win_d[i][K-1] = tap[i];
    end
  end

  // Line buffers and window are data-only; stale contents are masked by the counters.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb_q[0][cur_col] <= pixel_in;
      for (int j = 1; j < K - 1; j++) begin
        lb_q[j][cur_col] <= lb_q[j-1][cur_col];
      end
      win_q <= win_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          coef_q[i][j] <= '0;
        end
      end
    end else if (kernel_load) begin
      coef_q <= kernel_in;
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      rsum_d[i] = '0;
      for (int j = 0; j < K; j++) begin
        rsum_d[i] = rsum_d[i] + acc_t'(prod_q[i][j]);
      end
    end
    total = '0;
    for (int i = 0; i < K; i++) begin
      total = total + rsum_q[i];
    end
  end

`ifdef CONV_SATURATE_EN
  localparam acc_t MaxVal = {{(AW - WORD_SIZE + 1){1'b0}}, {(WORD_SIZE - 1){1'b1}}};
  localparam acc_t MinVal = ~MaxVal;
  acc_t shifted;

  always_comb begin
    shifted = total >>> SHIFT;
    if (shifted > MaxVal) begin
      ans_d = {1'b0, {(WORD_SIZE - 1){1'b1}}};
    end else if (shifted < MinVal) begin
      ans_d = {1'b1, {(WORD_SIZE - 1){1'b0}}};
    end else begin
      ans_d = word_t'(shifted);
    end
  end
`else
  always_comb begin
    ans_d = word_t'(total >>> SHIFT);
  end
`endif

  // Data stages load only when their valid is set; ans holds between results.
  always_ff @(posedge clk) begin
    if (win_done) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          prod_q[i][j] <= prod_t'(win_d[i][j]) * prod_t'(coef_q[i][j]);
        end
      end
    end
    if (v1_q) begin
      rsum_q <= rsum_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      row_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      ans_valid_q <= 1'b0;
      ans_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      v1_q        <= win_done;
      v2_q        <= v1_q;
      ans_valid_q <= v2_q;
      if (v2_q) begin
        ans_q <= ans_d;
      end
    end
  end

  assign ans       = ans_q;
  assign ans_valid = ans_valid_q;

endmodule
